// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the signed multiply/divide sequencer.
//   state_t    - sequencer FSM states
//   OP_MULT/OP_DIV - op select encodings
//   ITER_COUNT - shift-add / shift-subtract iterations per operation
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = $clog2(ITER_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

   // Magnitude of a signed 32-bit value read back as unsigned: 0x80000000
   // negates to itself, which is exactly 2^31 when treated as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the control unit and the sequencer.
//   start, op, op_a, op_b       - request from the control unit
//   busy, done, div_zero, hi, lo - status and results back from the sequencer
//   master modport: control unit side; slave modport: sequencer side
interface muldiv_if;
   import muldiv_pkg::*;

   logic        start;
   logic        op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, op_a, op_b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, op_a, op_b,
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on unsigned magnitudes.
//   op_i       - OP_MULT: shift-add step, OP_DIV: restoring shift-subtract step
//   acc_hi_i/acc_lo_i - accumulator halves in
//                mult: {partial product, remaining multiplier bits}
//                div:  {partial remainder, dividend bits / quotient bits}
//   operand_i  - multiplicand magnitude (mult) or divisor magnitude (div)
//   acc_hi_o/acc_lo_o - accumulator halves after the step
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic        op_i,
   input  logic [31:0] acc_hi_i,
   input  logic [31:0] acc_lo_i,
   input  logic [31:0] operand_i,
   output logic [31:0] acc_hi_o,
   output logic [31:0] acc_lo_o
);

   logic [32:0] sum;
   logic [32:0] rem_sh;
   logic [32:0] diff;

   always_comb begin
      sum    = {1'b0, acc_hi_i} + {1'b0, operand_i};
      rem_sh = {acc_hi_i, acc_lo_i[31]};
      diff   = rem_sh - {1'b0, operand_i};
      acc_hi_o = acc_hi_i;
      acc_lo_o = acc_lo_i;

      if (op_i == OP_MULT) begin
         // The carry out of the add shifts into the top bit so a 2^31 x 2^31
         // product never loses its MSB.
         if (acc_lo_i[0]) begin
            acc_hi_o = sum[32:1];
            acc_lo_o = {sum[0], acc_lo_i[31:1]};
         end else begin
            acc_hi_o = {1'b0, acc_hi_i[31:1]};
            acc_lo_o = {acc_hi_i[0], acc_lo_i[31:1]};
         end
      end else begin
         // No borrow means the shifted remainder covers the divisor.
         if (!diff[32]) begin
            acc_hi_o = diff[31:0];
            acc_lo_o = {acc_lo_i[30:0], 1'b1};
         end else begin
            acc_hi_o = rem_sh[31:0];
            acc_lo_o = {acc_lo_i[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed 32x32 multiply / 32/32 divide unit.
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - muldiv_if.slave: start/op/op_a/op_b in; busy/done/div_zero/hi/lo out
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// CALC  | 32 iterations on the magnitudes, counter 0..31
// FIX   | apply sign correction to the unsigned result
// DONE  | one-cycle done pulse (with div_zero on a divide by zero)
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_q, op_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic [31:0]       opnd_q, opnd_d;
   logic [31:0]       acc_hi_q, acc_hi_d;
   logic [31:0]       acc_lo_q, acc_lo_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic              dz_q, dz_d;

   logic [31:0]       step_hi;
   logic [31:0]       step_lo;
   logic [63:0]       prod_raw;
   logic [63:0]       prod_fix;
   logic [31:0]       quot_fix;
   logic [31:0]       rem_fix;
   logic              neg_res;

   muldiv_step u_step (
      .op_i      (op_q),
      .acc_hi_i  (acc_hi_q),
      .acc_lo_i  (acc_lo_q),
      .operand_i (opnd_q),
      .acc_hi_o  (step_hi),
      .acc_lo_o  (step_lo)
   );

   always_comb begin
      neg_res  = sign_a_q ^ sign_b_q;
      prod_raw = {acc_hi_q, acc_lo_q};
      prod_fix = neg_res  ? (~prod_raw + 64'd1) : prod_raw;
      quot_fix = neg_res  ? (~acc_lo_q + 32'd1) : acc_lo_q;
      // Remainder follows the dividend sign: truncation toward zero.
      rem_fix  = sign_a_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dz_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d     = bus.op;
               sign_a_d = bus.op_a[31];
               sign_b_d = bus.op_b[31];
               cnt_d    = '0;
               acc_hi_d = '0;
               if (bus.op == OP_MULT) begin
                  acc_lo_d = mag32(bus.op_b);
                  opnd_d   = mag32(bus.op_a);
               end else begin
                  acc_lo_d = mag32(bus.op_a);
                  opnd_d   = mag32(bus.op_b);
               end
               if ((bus.op == OP_DIV) && (bus.op_b == 32'd0)) begin
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = DONE;
            if (op_q == OP_MULT) begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MULT;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dz_q     <= dz_d;
      end
   end

   assign bus.busy     = (state_q == CALC) || (state_q == FIX);
   assign bus.done     = (state_q == DONE);
   assign bus.div_zero = dz_q && (state_q == DONE);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
      logic        edz;
      int          inj;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
      int          busy_cyc;
   } exp_t;

   logic clk;
   logic reset;
   muldiv_if bus();

   muldiv_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_chk = 0;
   int          n_err = 0;
   exp_t        sb_q[$];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;
   vec_t        tbl[12];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa;
      longint sb;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.dz = 1'b0;
      e.lat = 34;
      e.busy_cyc = 33;
      if (op == OP_MULT) begin
         r = sa * sb;
         e.hi = r[63:32];
         e.lo = r[31:0];
      end else if (b == 32'd0) begin
         e.dz = 1'b1;
         e.lat = 1;
         e.busy_cyc = 0;
         e.hi = last_hi;
         e.lo = last_lo;
      end else begin
         r = sa / sb;
         e.lo = r[31:0];
         r = sa % sb;
         e.hi = r[31:0];
      end
      return e;
   endfunction

   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int inj);
      exp_t e;
      int   lat;
      int   busy_n;
      logic dz_bad;
      e.hi = eh;
      e.lo = el;
      e.dz = edz;
      e.lat = edz ? 1 : 34;
      e.busy_cyc = edz ? 0 : 33;
      sb_q.push_back(e);

      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.op_a  = a;
      bus.op_b  = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = ~op;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
      lat = 1;
      busy_n = 0;
      dz_bad = 1'b0;
      while (!bus.done && lat <= 40) begin
         if (bus.busy) busy_n++;
         if (bus.div_zero) dz_bad = 1'b1;
         if (inj != 0 && lat == inj) begin
            bus.start = 1'b1;
            bus.op    = OP_MULT;
            bus.op_a  = 32'd3;
            bus.op_b  = 32'd4;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      e = sb_q.pop_front();
      if (!bus.done) begin
         chk("done_seen", 64'(bus.done), 64'd1);
      end else begin
         chk("latency", 64'(lat), 64'(e.lat));
         chk("busy_cycles", 64'(busy_n), 64'(e.busy_cyc));
         chk("hi", 64'(bus.hi), 64'(e.hi));
         chk("lo", 64'(bus.lo), 64'(e.lo));
         chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
         chk("div_zero_outside_done", 64'(dz_bad), 64'd0);
         last_hi = e.hi;
         last_lo = e.lo;
      end
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("dz_after_done", 64'(bus.div_zero), 64'd0);
      @(negedge clk);
      chk("idle_no_queued_start", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int   saw;
      exp_t e;
      logic rop;
      logic [31:0] ra;
      logic [31:0] rb;

      tbl[0]  = '{OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0};
      tbl[1]  = '{OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 0};
      tbl[2]  = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0};
      tbl[3]  = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0};
      tbl[4]  = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0};
      tbl[5]  = '{OP_MULT, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h1234_5678, 1'b0, 0};
      tbl[6]  = '{OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b1, 0};
      tbl[7]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 5};
      tbl[8]  = '{OP_MULT, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 0};
      tbl[9]  = '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 0};
      tbl[10] = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 0};
      tbl[11] = '{OP_DIV,  32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 0};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);

      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].edz, tbl[i].inj);
      end

      for (int i = 0; i < 10; i++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = (i == 4) ? 32'd0 : $urandom;
         if (i == 7) rb = 32'd3;
         e = model(rop, ra, rb);
         run_op(rop, ra, rb, e.hi, e.lo, e.dz, 0);
      end

      // Reset in the middle of CALC discards the operation.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.op_a  = 32'd5;
      bus.op_b  = 32'd6;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_calc_busy", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("calc_rst_busy", 64'(bus.busy), 64'd0);
      chk("calc_rst_done", 64'(bus.done), 64'd0);
      chk("calc_rst_hi", 64'(bus.hi), 64'd0);
      chk("calc_rst_lo", 64'(bus.lo), 64'd0);
      last_hi = '0;
      last_lo = '0;
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) saw = 1;
      end
      chk("no_done_after_calc_rst", 64'(saw), 64'd0);
      run_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.op_a  = 32'd9;
      bus.op_b  = 32'd9;
      reset     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      reset     = 1'b0;
      chk("rst_start_busy", 64'(bus.busy), 64'd0);
      chk("rst_start_lo", 64'(bus.lo), 64'd0);
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) saw = 1;
      end
      chk("rst_start_no_done", 64'(saw), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
